// File: rtl/rns_modadd_pipe.sv
// ============================================================================
// rns_modadd_pipe: two-stage elastic residue adder/subtractor for the moduli
// {2^N-1, 2^N, 2^N+1}. Optional macro RNS_RANGE_CHECK_EN adds operand checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rns_modadd_pipe #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sub,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [N:0]   a2,
  input  logic [N:0]   b2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r0,
  output logic [N-1:0] r1,
  output logic [N:0]   r2,
  output logic [2:0]   out_err
);

  localparam logic [N+1:0] C_M2      = {2'b01, {(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   C_M2_LOW  = {1'b1, {(N-1){1'b0}}, 1'b1};

  logic           v1_q, v2_q;
  logic           sub1_q;
  logic [N:0]     s0_q;
  logic [N-1:0]   s1_q;
  logic [N+1:0]   s2_q;
  logic           w_load1, w_adv2;

  assign in_ready = !v1_q || !v2_q || out_ready;
  assign w_load1  = in_valid && in_ready;
  assign w_adv2   = v1_q && (!v2_q || out_ready);
  assign out_valid = v2_q;

  // Stage 1 raw sums
  logic [N-1:0] w_b0x;
  logic [N:0]   s0_d;
  logic [N-1:0] s1_d;
  logic [N+1:0] s2_d;

  assign w_b0x = in_sub ? ~b0 : b0;
  assign s0_d  = {1'b0, a0} + {1'b0, w_b0x};
  assign s1_d  = in_sub ? (a1 - b1) : (a1 + b1);
  assign s2_d  = in_sub ? ({1'b0, a2} - {1'b0, b2}) : ({1'b0, a2} + {1'b0, b2});

  // Stage 2 modular correction
  logic [N-1:0] w_t0;
  logic [N-1:0] r0_d;
  logic [N-1:0] r1_d;
  logic [N:0]   r2_d;

  assign w_t0 = s0_q[N-1:0] + {{(N-1){1'b0}}, s0_q[N]};

  always_comb begin
    r0_d = (w_t0 == {N{1'b1}}) ? '0 : w_t0;
    r1_d = s1_q;
    r2_d = s2_q[N:0];
    if (sub1_q) begin
      if (s2_q[N+1]) r2_d = s2_q[N:0] + C_M2_LOW;
    end else begin
      if (s2_q >= C_M2) r2_d = s2_q[N:0] - C_M2_LOW;
    end
  end

  logic [N-1:0] r0_q, r1_q;
  logic [N:0]   r2_q;

`ifdef RNS_RANGE_CHECK_EN
  localparam logic [N:0] C_P2N = {1'b1, {N{1'b0}}};
  logic [2:0] err_d, err1_q, err2_q;

  assign err_d = {(a2 > C_P2N) || (b2 > C_P2N), 1'b0,
                  (a0 == {N{1'b1}}) || (b0 == {N{1'b1}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1_q <= '0;
      err2_q <= '0;
    end else begin
      if (w_load1) err1_q <= err_d;
      if (w_adv2)  err2_q <= err1_q;
    end
  end

  assign out_err = err2_q;
  assign r0 = r0_q;
  assign r1 = r1_q;
  assign r2 = r2_q;
`else
  assign out_err = 3'b000;
  assign r0 = r0_q;
  assign r1 = r1_q;
  assign r2 = r2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sub1_q <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      r0_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
    end else begin
      if (w_load1) begin
        v1_q   <= 1'b1;
        sub1_q <= in_sub;
        s0_q   <= s0_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
      end else if (w_adv2) begin
        v1_q <= 1'b0;
      end

      if (w_adv2) begin
        v2_q <= 1'b1;
`ifdef RNS_RANGE_CHECK_EN
        // Erroneous channels are zeroed; good channels pass through
        r0_q <= err1_q[0] ? '0 : r0_d;
        r1_q <= r1_d;
        r2_q <= err1_q[2] ? '0 : r2_d;
`else
        r0_q <= r0_d;
        r1_q <= r1_d;
        r2_q <= r2_d;
`endif
      end else if (out_ready) begin
        v2_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rns_modadd_pipe.sv
// Directed self-checking bench for rns_modadd_pipe with N=3.
`default_nettype none

module tb_rns_modadd_pipe;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sub = 1'b0;
  logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [N:0]   a2 = '0, b2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] r0, r1;
  logic [N:0]   r2;
  logic [2:0]   out_err;

  int total = 0;
  int bad = 0;

  rns_modadd_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .out_valid(out_valid), .out_ready(out_ready),
    .r0(r0), .r1(r1), .r2(r2), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sub, input int x0, input int x1, input int x2,
                       input int y0, input int y1, input int y2);
    in_valid = 1'b1;
    in_sub   = sub;
    a0 = x0[N-1:0]; a1 = x1[N-1:0]; a2 = x2[N:0];
    b0 = y0[N-1:0]; b1 = y1[N-1:0]; b2 = y2[N:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int e0, input int e1, input int e2,
                           input int eerr);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".r0"}, 32'(r0), 32'(e0));
    check({tag, ".r1"}, 32'(r1), 32'(e1));
    check({tag, ".r2"}, 32'(r2), 32'(e2));
    check({tag, ".err"}, 32'(out_err), 32'(eerr));
  endtask

  initial begin
    // Reset with active inputs
    drive(1'b0, 5, 6, 8, 4, 3, 4);
    tick(); tick(); tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.r0", 32'(r0), 32'd0);
    check("rst.r1", 32'(r1), 32'd0);
    check("rst.r2", 32'(r2), 32'd0);
    check("rst.err", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Add: (5,6,8)+(4,3,4) -> (2,1,3)
    drive(1'b0, 5, 6, 8, 4, 3, 4);
    tick();
    in_valid = 1'b0;
    check("add.lat1", 32'(out_valid), 32'd0);
    tick();
    check_out("add", 2, 1, 3, 0);
    tick();
    check("add.drain", 32'(out_valid), 32'd0);

    // Subtract: (1,2,0)-(3,5,1) -> (5,5,8)
    drive(1'b1, 1, 2, 0, 3, 5, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check_out("sub", 5, 5, 8, 0);

    // Canonical zero: 3+4 mod 7 = 0, 8+1 mod 9 = 0
    drive(1'b0, 3, 0, 8, 4, 0, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check_out("zero", 0, 0, 0, 0);
    tick();

    // Backpressure: three back-to-back transactions, capacity two
    out_ready = 1'b0;
    drive(1'b0, 1, 1, 1, 1, 1, 1);        // T1 -> (2,2,2)
    tick();
    check("bp.rdy1", 32'(in_ready), 32'd1);
    drive(1'b0, 6, 7, 8, 6, 7, 8);        // T2 -> (5,6,7)
    tick();
    check("bp.rdy2", 32'(in_ready), 32'd0);
    drive(1'b1, 0, 0, 0, 1, 1, 1);        // T3 -> (6,7,8)
    tick();
    check("bp.rdy3", 32'(in_ready), 32'd0);
    check_out("bp.hold", 2, 2, 2, 0);
    tick();
    check_out("bp.hold2", 2, 2, 2, 0);
    out_ready = 1'b1;
    #1;
    check("bp.rdy_comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_out("bp.t2", 5, 6, 7, 0);
    tick();
    check_out("bp.t3", 6, 7, 8, 0);
    tick();
    check("bp.empty", 32'(out_valid), 32'd0);

    // Range error on channel 2
    drive(1'b0, 5, 6, 10, 4, 3, 4);
    tick();
    in_valid = 1'b0;
    tick();
    check("rng.valid", 32'(out_valid), 32'd1);
    check("rng.r0", 32'(r0), 32'd2);
    check("rng.r1", 32'(r1), 32'd1);
`ifdef RNS_RANGE_CHECK_EN
    check("rng.r2", 32'(r2), 32'd0);
    check("rng.err", 32'(out_err), 32'd4);
`else
    check("rng.err", 32'(out_err), 32'd0);
`endif
    tick();

    // Reset mid-operation discards in-flight data
    drive(1'b0, 1, 1, 1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst.after", 32'(out_valid), 32'd0);
    tick();
    check("midrst.after2", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
